// File: rtl/iter_mul_unit_pkg.sv
// Shared types and constants for the iterative multiplier: FSM state encoding,
// operand/product widths and the BITS_PER_CYCLE legality check.
package mul_pkg;
  localparam int MUL_WIDTH  = 32;
  localparam int PROD_WIDTH = 64;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic bit bpc_legal(input int bpc);
    return (bpc == 1 || bpc == 2 || bpc == 4 || bpc == 8) && (MUL_WIDTH % bpc == 0);
  endfunction
endpackage

// File: rtl/iter_mul_unit_if.sv
// Multiply handshake between the execute stage (master) and the multiplier (slave).
interface iter_mul_unit_if;
  logic                            enable;
  logic                            is_unsign;
  logic [mul_pkg::MUL_WIDTH-1:0]   a;
  logic [mul_pkg::MUL_WIDTH-1:0]   b;
  logic [mul_pkg::PROD_WIDTH-1:0]  result;
  logic                            done;
  logic                            busy;

  modport master (output enable, is_unsign, a, b, input result, done, busy);
  modport slave  (input enable, is_unsign, a, b, output result, done, busy);
endinterface

// File: rtl/iter_mul_unit_step.sv
// One iteration's partial product: mcand times a BITS_PER_CYCLE-wide multiplier
// chunk, shifted into place by the iteration count.
module mul_step
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [MUL_WIDTH-1:0]      mcand,
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  logic [5:0]                count,
  output logic [PROD_WIDTH-1:0]     partial
);
  localparam int PW = MUL_WIDTH + BITS_PER_CYCLE;

  logic [PW-1:0] terms [BITS_PER_CYCLE];
  logic [PW-1:0] prod;
  logic [5:0]    shamt;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
    assign terms[gi] = chunk[gi] ? ({{BITS_PER_CYCLE{1'b0}}, mcand} << gi) : '0;
  end

  always_comb begin
    prod = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      prod = prod + terms[i];
    end
  end

  assign shamt   = count * 6'(BITS_PER_CYCLE);
  assign partial = {{(PROD_WIDTH-PW){1'b0}}, prod} << shamt;
endmodule

// File: rtl/iter_mul_unit.sv
// Multi-cycle 32x32->64 multiplier: sign-magnitude shift-add over N iterations,
// sign fix-up, then a one-cycle done strobe.
module iter_mul_unit
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic           sys_clk,
  input  logic           rst,
  iter_mul_unit_if.slave bus
);
  localparam int         N    = MUL_WIDTH / BITS_PER_CYCLE;
  localparam logic [5:0] LAST = 6'(N - 1);

  if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_param
    $error("iter_mul_unit: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t                state_reg, state_next;
  logic [MUL_WIDTH-1:0]  mcand_reg, mplier_reg;
  logic                  neg_reg;
  logic [PROD_WIDTH-1:0] acc_reg, result_reg, partial;
  logic [5:0]            count_reg;
  logic [MUL_WIDTH-1:0]  a_mag, b_mag;

  // Two's-complement negate also maps 0x80000000 onto itself, which is its magnitude.
  assign a_mag = (!bus.is_unsign && bus.a[MUL_WIDTH-1]) ? (~bus.a + 32'd1) : bus.a;
  assign b_mag = (!bus.is_unsign && bus.b[MUL_WIDTH-1]) ? (~bus.b + 32'd1) : bus.b;

  mul_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .mcand   (mcand_reg),
    .chunk   (mplier_reg[BITS_PER_CYCLE-1:0]),
    .count   (count_reg),
    .partial (partial)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.enable) state_next = CALC;
      CALC:    if (!bus.enable) state_next = IDLE;
               else if (count_reg == LAST) state_next = FIX;
      FIX:     state_next = bus.enable ? DONE : IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.done = 1'b0;
    bus.busy = 1'b0;
    case (state_reg)
      CALC, FIX: bus.busy = 1'b1;
      DONE:      bus.done = 1'b1;
      default:   ;
    endcase
  end

  // Datapath only advances while the request is still held, so an abort leaves result untouched.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      acc_reg    <= '0;
      count_reg  <= '0;
      result_reg <= '0;
    end else if (bus.enable) begin
      case (state_reg)
        IDLE: begin
          mcand_reg  <= a_mag;
          mplier_reg <= b_mag;
          neg_reg    <= !bus.is_unsign && (bus.a[MUL_WIDTH-1] ^ bus.b[MUL_WIDTH-1]);
          acc_reg    <= '0;
          count_reg  <= '0;
        end
        CALC: begin
          acc_reg    <= acc_reg + partial;
          mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
          count_reg  <= count_reg + 6'd1;
        end
        FIX:     result_reg <= neg_reg ? (~acc_reg + 64'd1) : acc_reg;
        default: ;
      endcase
    end
  end

  assign bus.result = result_reg;
endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed-vector bench for iter_mul_unit: latency, signed/unsigned products,
// back-to-back, abort, reset and a BITS_PER_CYCLE sweep.
module tb_iter_mul_unit;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  iter_mul_unit_if bus ();
  iter_mul_unit_if bus1 ();
  iter_mul_unit_if bus4 ();
  iter_mul_unit_if bus8 ();

  iter_mul_unit dut (.sys_clk(clk), .rst(rst), .bus(bus));
  iter_mul_unit #(.BITS_PER_CYCLE(1)) dut1 (.sys_clk(clk), .rst(rst), .bus(bus1));
  iter_mul_unit #(.BITS_PER_CYCLE(4)) dut4 (.sys_clk(clk), .rst(rst), .bus(bus4));
  iter_mul_unit #(.BITS_PER_CYCLE(8)) dut8 (.sys_clk(clk), .rst(rst), .bus(bus8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the negedge where the request is driven; it is sampled at the next posedge.
  task automatic start(input logic uns, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.is_unsign = uns;
    bus.a         = av;
    bus.b         = bv;
    bus.enable    = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic uns, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp);
    start(uns, av, bv);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      chk({tag, "_done"}, 64'(bus.done), 64'(c == 18));
      chk({tag, "_busy"}, 64'(bus.busy), 64'(c <= 17));
      if (c == 3) begin
        bus.a = ~av;
        bus.b = ~bv;
        bus.is_unsign = ~uns;
      end
    end
    chk({tag, "_result"}, bus.result, exp);
    $display("op %s: a=%h b=%h unsigned=%0b result=%h", tag, av, bv, uns, bus.result);
    bus.enable = 1'b0;
  endtask

  task automatic sweep(input string tag, input logic uns, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] exp;
    logic signed [63:0] sa, sb;
    sa = {{32{av[31]}}, av};
    sb = {{32{bv[31]}}, bv};
    exp = uns ? ({32'h0, av} * {32'h0, bv}) : 64'(sa * sb);
    @(negedge clk);
    bus1.is_unsign = uns; bus1.a = av; bus1.b = bv; bus1.enable = 1'b1;
    bus4.is_unsign = uns; bus4.a = av; bus4.b = bv; bus4.enable = 1'b1;
    bus8.is_unsign = uns; bus8.a = av; bus8.b = bv; bus8.enable = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      chk({tag, "_b1_done"}, 64'(bus1.done), 64'(c == 34));
      chk({tag, "_b4_done"}, 64'(bus4.done), 64'(c == 10));
      chk({tag, "_b8_done"}, 64'(bus8.done), 64'(c == 6));
      if (c == 6)  begin chk({tag, "_b8_result"}, bus8.result, exp); bus8.enable = 1'b0; end
      if (c == 10) begin chk({tag, "_b4_result"}, bus4.result, exp); bus4.enable = 1'b0; end
      if (c == 34) begin chk({tag, "_b1_result"}, bus1.result, exp); bus1.enable = 1'b0; end
    end
    $display("sweep %s: a=%h b=%h unsigned=%0b expected=%h", tag, av, bv, uns, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;  bus.is_unsign = 1'b0;  bus.a = '0;  bus.b = '0;
    bus1.enable = 1'b0; bus1.is_unsign = 1'b0; bus1.a = '0; bus1.b = '0;
    bus4.enable = 1'b0; bus4.is_unsign = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.enable = 1'b0; bus8.is_unsign = 1'b0; bus8.a = '0; bus8.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", bus.result, 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_state", 64'(dut.state_reg), 64'(IDLE));
    $display("reset: result=%h done=%0b busy=%0b", bus.result, bus.done, bus.busy);
    rst = 1'b0;

    run_op("t1_umax", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("t2_sneg1x5", 1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op("t2_sminxneg1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("t2_uminxmax", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h7FFF_FFFF_8000_0000);

    // Back-to-back with enable held through DONE and the following IDLE cycle.
    start(1'b1, 32'd3, 32'd7);
    for (int c = 1; c <= 37; c++) begin
      @(negedge clk);
      chk("t3_done", 64'(bus.done), 64'(c == 18 || c == 37));
      chk("t3_busy", 64'(bus.busy), 64'(c <= 17 || (c >= 20 && c <= 36)));
      if (c == 18) chk("t3_result1", bus.result, 64'd21);
      if (c == 19) begin
        bus.is_unsign = 1'b0;
        bus.a = 32'd6;
        bus.b = 32'hFFFF_FFFE;
      end
    end
    chk("t3_result2", bus.result, 64'hFFFF_FFFF_FFFF_FFF4);
    $display("op t3_b2b: result=%h", bus.result);
    bus.enable = 1'b0;

    // Abort in cycle 5, restart in cycle 8.
    start(1'b1, 32'h0000_1234, 32'h0000_0010);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      chk("t4_done", 64'(bus.done), 64'(c == 26));
      if (c < 26) chk("t4_result_hold", bus.result, 64'hFFFF_FFFF_FFFF_FFF4);
      if (c >= 6 && c <= 8) chk("t4_idle", 64'(dut.state_reg), 64'(IDLE));
      if (c == 5) bus.enable = 1'b0;
      if (c == 8) bus.enable = 1'b1;
    end
    chk("t4_result", bus.result, 64'h0000_0000_0001_2340);
    $display("op t4_abort_restart: result=%h", bus.result);
    bus.enable = 1'b0;

    run_op("t5_pre", 1'b1, 32'h0000_0010, 32'h0000_0020, 64'h200);
    start(1'b0, 32'h0000_0123, 32'hFFFF_FF00);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    chk("t5_state", 64'(dut.state_reg), 64'(IDLE));
    chk("t5_done", 64'(bus.done), 64'h0);
    chk("t5_busy", 64'(bus.busy), 64'h0);
    chk("t5_result", bus.result, 64'h0);
    $display("op t5_reset: result=%h busy=%0b", bus.result, bus.busy);
    rst = 1'b0;

    sweep("t6_u", 1'b1, 32'h89AB_CDEF, 32'h7654_3210);
    sweep("t6_s", 1'b0, 32'h89AB_CDEF, 32'h7654_3210);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
